pwm_duty_ramp_ctrl: RTL and testbench
=====================================

# pwm_duty_ramp_ctrl

Sequencer that moves the PWM generator's duty cycle from its current value to a requested target. It issues one single-cycle increment or decrement pulse per step, with a programmable minimum spacing between steps, and only on PWM period boundaries. It sits between the control/host logic and the PWM generator's inc/dec duty inputs, and is the only driver of those inputs. It keeps a shadow copy of the generator's duty value.

## Interface
- `DUTY_W`, 4: width of duty values (units of 10%).
- `DUTY_MAX`, 10: highest legal duty step (100%).
- `INIT_DUTY`, 5: duty value after reset; must equal the generator's reset duty.
- `STEP_INTERVAL`, 4: minimum clk cycles between steps, ≥1.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `period_wrap` in 1: high for one cycle when the PWM counter is at its last count (9).
- `target_valid` in 1: a target request is present.
- `target_ready` out 1: the block can accept a target.
- `target_duty` in DUTY_W: requested duty step.
- `abort` in 1: stop the ramp in progress.
- `inc_pulse` out 1: one-cycle +1 step to the generator.
- `dec_pulse` out 1: one-cycle −1 step to the generator.
- `duty_cur` out DUTY_W: shadow of the generator duty.
- `busy` out 1: a ramp is in progress.
- `done` out 1: one-cycle pulse when the target has been reached.

## Operation
States:
- **IDLE**
  - `target_ready`=1, `busy`=0.
  - On `target_valid`: latch `tgt` = min(`target_duty`, `DUTY_MAX`). Values 11–15 clamp to 10.
  - If `tgt` == `duty_cur`: `done` pulses, state stays IDLE, no step pulses.
  - Otherwise: load the interval counter with `STEP_INTERVAL`−1 and go to RAMP.
  - `abort` is ignored.
- **RAMP**
  - `target_ready`=0, `busy`=1. `target_valid` is ignored and not queued.
  - The interval counter decrements each cycle and saturates at 0.
  - Step condition: counter==0 and `period_wrap`=1. On a step:
    - Pulse `inc_pulse` if `tgt` > `duty_cur`, otherwise `dec_pulse`.
    - `duty_cur` moves ±1.
    - Reload the counter with `STEP_INTERVAL`−1.
  - If the new `duty_cur` equals `tgt`: pulse `done` together with that final step pulse and return to IDLE.
  - `abort`=1 takes priority over a step in the same cycle. Effects:
    - Return to IDLE.
    - No pulse is issued.
    - `duty_cur` is held.
    - `done` is not asserted.
- `inc_pulse` and `dec_pulse` are never high together. `duty_cur` never leaves the range 0..`DUTY_MAX`.
- `duty_cur` always equals the generator's duty, given common reset and this block as sole driver.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, `duty_cur`=`INIT_DUTY`.
  - `inc_pulse`, `dec_pulse`, `done`, `busy` = 0; `target_ready`=1.
  - Interval counter = 0; `tgt` = `INIT_DUTY`.
- All outputs are registered. `target_ready` and `busy` decode the registered state.
- Handshake: a request transfers on the rising edge where `target_valid` && `target_ready`. `busy` rises in the next cycle.
- Step latency: for a step condition seen before edge E, the pulse is high during the cycle after E. `duty_cur` updates at E.
- Step spacing: with `STEP_INTERVAL`=S, consecutive pulses are at least max(S, 10) cycles apart. They are always exactly one PWM period multiple apart, because steps are gated by `period_wrap`.
- A ramp of k steps needs k `period_wrap` events.
- Equal-target `done`: high in the cycle after acceptance.
- Abort: `busy` falls in the cycle after the edge that samples `abort`.
- A new target may be accepted in the first IDLE cycle after `done` or abort.
- `rst` asserted mid-ramp: the block returns to reset values immediately, and no partial pulse is issued after reset.

## Structure
- Shared package `pwm_pkg` holds:
  - `DUTY_W`, `DUTY_MAX`, `INIT_DUTY`.
  - Enum `ramp_state_t` {IDLE, RAMP}.
  - The period length constant 10, shared with the generator.
- One sub-module, `pwm_step_timer`:
  - Loadable down-counter with saturation at 0.
  - Width = $clog2(`STEP_INTERVAL`+1).
  - Outputs `expired`.
- The FSM, clamp, compare and shadow register are all in `pwm_duty_ramp_ctrl`.

## Test plan
1. **Reset:** apply `rst`, release it, idle 20 cycles → `duty_cur`=5, `target_ready`=1, no pulses, `done`=0.
2. **Ramp up:** target 8, S=4, `period_wrap` every 10 cycles → exactly 3 `inc_pulse`, each 10 cycles apart. `duty_cur` goes 6, 7, 8. `done` is high with the third pulse.
3. **Ramp down with clamp:** target 15 from 5 → 5 `inc_pulse`, final `duty_cur`=10. Then target 0 → 10 `dec_pulse`, `duty_cur`=0, `done` asserted once.
4. **Equal target:** target 5 at `duty_cur`=5 → `done` in the next cycle, no pulses, `busy` stays 0.
5. **Abort:** target 9, abort after the 2nd pulse, in the same cycle as an eligible step → no 3rd pulse, `duty_cur`=7, `done`=0, `target_ready`=1 next cycle.
6. **Busy and mid-ramp reset:** present target 2 while in RAMP → it is ignored and the ramp completes to the original target. Assert `rst` mid-ramp → `duty_cur`=5 immediately and all pulses are low.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM constants, ramp FSM state type and target clamp helper.
// The period length is shared with the PWM generator so both agree on what a period is.
package pwm_pkg;
  localparam int DUTY_W = 4;
  localparam logic [DUTY_W-1:0] DUTY_MAX  = 4'd10;
  localparam logic [DUTY_W-1:0] INIT_DUTY = 4'd5;
  localparam int PERIOD_LEN = 10;

  typedef enum logic {IDLE, RAMP} ramp_state_t;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction
endpackage

// File: rtl/pwm_step_timer.sv
// Loadable down-counter that saturates at zero; expired flags the minimum step spacing has elapsed.
module pwm_step_timer #(
  parameter int STEP_INTERVAL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);
  localparam int CW = $clog2(STEP_INTERVAL + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(STEP_INTERVAL - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Steps the PWM generator duty toward a requested target, one inc/dec pulse per eligible
// period boundary, keeping a shadow of the generator duty; all outputs registered.
module pwm_duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int STEP_INTERVAL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              period_wrap,
  input  logic              target_valid,
  output logic              target_ready,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              abort,
  output logic              inc_pulse,
  output logic              dec_pulse,
  output logic [DUTY_W-1:0] duty_cur,
  output logic              busy,
  output logic              done
);
  ramp_state_t       state, state_nxt;
  logic [DUTY_W-1:0] tgt, tgt_nxt, duty_nxt, req;
  logic              inc_nxt, dec_nxt, done_nxt;
  logic              timer_load, timer_expired;

  pwm_step_timer #(.STEP_INTERVAL(STEP_INTERVAL)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tgt_nxt    = tgt;
    duty_nxt   = duty_cur;
    inc_nxt    = 1'b0;
    dec_nxt    = 1'b0;
    done_nxt   = 1'b0;
    timer_load = 1'b0;
    req        = clamp_duty(target_duty);
    case (state)
      IDLE: begin
        if (target_valid) begin
          tgt_nxt = req;
          if (req == duty_cur) begin
            done_nxt = 1'b1;
          end else begin
            timer_load = 1'b1;
            state_nxt  = RAMP;
          end
        end
      end
      RAMP: begin
        // Abort wins over a step that is eligible in the same cycle.
        if (abort) begin
          state_nxt = IDLE;
        end else if (timer_expired && period_wrap) begin
          timer_load = 1'b1;
          if (tgt > duty_cur) begin
            inc_nxt  = 1'b1;
            duty_nxt = duty_cur + 1'b1;
          end else begin
            dec_nxt  = 1'b1;
            duty_nxt = duty_cur - 1'b1;
          end
          if (duty_nxt == tgt) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt       <= INIT_DUTY;
      duty_cur  <= INIT_DUTY;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      done      <= 1'b0;
    end else begin
      tgt       <= tgt_nxt;
      duty_cur  <= duty_nxt;
      inc_pulse <= inc_nxt;
      dec_pulse <= dec_nxt;
      done      <= done_nxt;
    end
  end

  assign target_ready = (state == IDLE);
  assign busy         = (state == RAMP);
endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Bench for pwm_duty_ramp_ctrl: directed scenarios plus a randomized run against an elapsed-time reference model.
module tb_pwm_duty_ramp_ctrl;
  import pwm_pkg::*;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst, period_wrap, target_valid, abort;
  logic [DUTY_W-1:0] target_duty, duty_cur;
  logic target_ready, inc_pulse, dec_pulse, busy, done;
  logic [9:0] dut_vec;

  int tests = 0, fails = 0;
  int pw_cnt = 0, cyc = 0;

  // Reference model state: duty, target, edges since last step/accept, ramp active.
  int m_duty, m_tgt, m_since;
  bit m_busy, m_inc, m_dec, m_done;

  always #5 clk = ~clk;

  pwm_duty_ramp_ctrl #(.STEP_INTERVAL(S)) dut (
    .clk(clk), .rst(rst), .period_wrap(period_wrap), .target_valid(target_valid),
    .target_ready(target_ready), .target_duty(target_duty), .abort(abort),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .duty_cur(duty_cur),
    .busy(busy), .done(done)
  );

  assign dut_vec = {inc_pulse, dec_pulse, done, busy, target_ready, duty_cur};

  function automatic logic [9:0] exp_vec();
    return {m_inc, m_dec, m_done, m_busy, ~m_busy, DUTY_W'(m_duty)};
  endfunction

  task automatic model_reset();
    m_duty = 5; m_tgt = 5; m_since = 0;
    m_busy = 0; m_inc = 0; m_dec = 0; m_done = 0;
  endtask

  task automatic model_edge();
    int t;
    m_inc = 0; m_dec = 0; m_done = 0;
    if (!m_busy) begin
      if (target_valid) begin
        t = (int'(target_duty) > 10) ? 10 : int'(target_duty);
        if (t == m_duty) m_done = 1;
        else begin m_tgt = t; m_busy = 1; m_since = 0; end
      end
    end else begin
      m_since++;
      if (abort) m_busy = 0;
      else if (period_wrap && m_since >= S) begin
        m_since = 0;
        if (m_tgt > m_duty) begin m_duty++; m_inc = 1; end
        else begin m_duty--; m_dec = 1; end
        if (m_duty == m_tgt) begin m_done = 1; m_busy = 0; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    cyc++;
    #1;
    pw_cnt = (pw_cnt + 1) % 10;
    period_wrap = (pw_cnt == 9);
  endtask

  task automatic do_reset();
    rst = 1; target_valid = 0; abort = 0; target_duty = '0;
    model_reset();
    repeat (2) tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; target_valid = 0; abort = 0; target_duty = '0;
    #1;
    tests++;
    if (dut_vec !== 10'b00_0_0_1_0101) begin
      fails++; $display("FAIL reset_async got=%b exp=%b", dut_vec, 10'b00_0_0_1_0101);
    end
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_ramp_up();
    int pc[$];
    int done_cyc;
    bit fin;
    done_cyc = -1; fin = 0;
    do_reset();
    target_valid = 1; target_duty = 4'd8; tick(); target_valid = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL ramp_up_cycle cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
      if (inc_pulse) begin
        tests++;
        if (duty_cur !== DUTY_W'(6 + pc.size())) begin
          fails++; $display("FAIL ramp_up_duty got=%0d exp=%0d", duty_cur, 6 + pc.size());
        end
        pc.push_back(cyc);
      end
      if (done) begin done_cyc = cyc; fin = 1; end
      else tick();
    end
    tests++;
    if (!fin || pc.size() != 3) begin
      fails++; $display("FAIL ramp_up_count got=%0d exp=3 fin=%0d", pc.size(), fin);
    end else begin
      tests++;
      if (pc[1] - pc[0] != 10 || pc[2] - pc[1] != 10) begin
        fails++; $display("FAIL ramp_up_spacing got=%0d,%0d exp=10,10", pc[1] - pc[0], pc[2] - pc[1]);
      end
      tests++;
      if (done_cyc != pc[2]) begin
        fails++; $display("FAIL ramp_up_done_align got=%0d exp=%0d", done_cyc, pc[2]);
      end
    end
  endtask

  task automatic test_clamp_and_down();
    int n_inc, n_dec, n_done;
    bit to;
    do_reset();
    for (int leg = 0; leg < 2; leg++) begin
      n_inc = 0; n_dec = 0; n_done = 0; to = 1;
      target_valid = 1; target_duty = (leg == 0) ? 4'd15 : 4'd0; tick(); target_valid = 0;
      for (int i = 0; i < 300; i++) begin
        n_inc += int'(inc_pulse); n_dec += int'(dec_pulse); n_done += int'(done);
        if (!busy) begin to = 0; break; end
        tick();
      end
      repeat (3) begin tick(); n_done += int'(done); end
      tests++;
      if (to || n_inc != (leg == 0 ? 5 : 0) || n_dec != (leg == 0 ? 0 : 10) || n_done != 1) begin
        fails++; $display("FAIL clamp_leg%0d inc=%0d dec=%0d done=%0d timeout=%0d", leg, n_inc, n_dec, n_done, to);
      end
      tests++;
      if (duty_cur !== ((leg == 0) ? 4'd10 : 4'd0)) begin
        fails++; $display("FAIL clamp_final_leg%0d got=%0d exp=%0d", leg, duty_cur, (leg == 0) ? 10 : 0);
      end
    end
  endtask

  task automatic test_equal();
    int n_pulse;
    n_pulse = 0;
    do_reset();
    target_valid = 1; target_duty = 4'd5; tick(); target_valid = 0;
    tests++;
    if (dut_vec !== 10'b00_1_0_1_0101) begin
      fails++; $display("FAIL equal_done got=%b exp=%b", dut_vec, 10'b00_1_0_1_0101);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      n_pulse += int'(inc_pulse) + int'(dec_pulse) + int'(done) + int'(busy);
    end
    tests++;
    if (n_pulse != 0) begin
      fails++; $display("FAIL equal_quiet got=%0d events exp=0", n_pulse);
    end
  endtask

  task automatic test_abort();
    int n_inc, n_pulse;
    n_inc = 0; n_pulse = 0;
    do_reset();
    target_valid = 1; target_duty = 4'd9; tick(); target_valid = 0;
    for (int i = 0; i < 100 && n_inc < 2; i++) begin
      tick();
      n_inc += int'(inc_pulse);
    end
    for (int i = 0; i < 20 && !period_wrap; i++) tick();
    abort = 1; tick(); abort = 0;
    tests++;
    if (dut_vec !== 10'b00_0_0_1_0111 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL abort_state got=%b exp=%b n_inc=%0d", dut_vec, 10'b00_0_0_1_0111, n_inc);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      n_pulse += int'(inc_pulse) + int'(dec_pulse) + int'(done);
    end
    tests++;
    if (n_pulse != 0 || duty_cur !== 4'd7) begin
      fails++; $display("FAIL abort_hold events=%0d duty=%0d exp 0 events duty 7", n_pulse, duty_cur);
    end
  endtask

  task automatic test_busy_and_reset();
    int n_dec, n_pulse;
    bit fin;
    n_dec = 0; n_pulse = 0; fin = 0;
    do_reset();
    target_valid = 1; target_duty = 4'd8; tick(); target_duty = 4'd2;
    for (int i = 0; i < 200 && !fin; i++) begin
      tick();
      fin = done;
    end
    target_valid = 0;
    tests++;
    if (!fin || duty_cur !== 4'd8) begin
      fails++; $display("FAIL busy_ignore duty=%0d done=%0d exp duty 8 done 1", duty_cur, fin);
    end
    target_valid = 1; target_duty = 4'd2; tick(); target_valid = 0;
    for (int i = 0; i < 100 && n_dec < 1; i++) begin
      tick();
      n_dec += int'(dec_pulse);
    end
    repeat (2) tick();
    #2 rst = 1;
    #1;
    model_reset();
    tests++;
    if (dut_vec !== 10'b00_0_0_1_0101 || n_dec != 1) begin
      fails++; $display("FAIL midramp_reset got=%b exp=%b n_dec=%0d", dut_vec, 10'b00_0_0_1_0101, n_dec);
    end
    repeat (2) tick();
    rst = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_pulse += int'(inc_pulse) + int'(dec_pulse) + int'(done) + int'(busy);
    end
    tests++;
    if (n_pulse != 0 || duty_cur !== 4'd5) begin
      fails++; $display("FAIL post_reset_quiet events=%0d duty=%0d exp 0 events duty 5", n_pulse, duty_cur);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      target_valid = ($urandom_range(0, 3) == 0);
      target_duty  = DUTY_W'($urandom_range(0, 15));
      abort        = ($urandom_range(0, 59) == 0);
      tick();
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
    target_valid = 0; abort = 0;
  endtask

  initial begin
    period_wrap = 0;
    model_reset();
    test_reset();
    test_ramp_up();
    test_clamp_and_down();
    test_equal();
    test_abort();
    test_busy_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
